addsub_serial_n: RTL and testbench
==================================

# addsub_serial_n

Parametrised, multi-cycle two's-complement adder/subtractor for the arithmetic datapath. It processes a WIDTH-bit operand pair DIGIT bits per clock using a registered carry chain, and computes A+B or A−B. It reports carry/borrow, signed overflow and zero flags. It uses a valid/ready handshake on both input and output, so it can sit between a register file/controller and a result consumer that may stall.

## Interface
- WIDTH, default 8: operand and result width in bits; must be ≥1.
- DIGIT, default 2: bits processed per RUN cycle; 1 ≤ DIGIT ≤ WIDTH and WIDTH % DIGIT == 0 (elaboration error otherwise).
- N (local) = WIDTH/DIGIT: RUN cycles per operation.

Ports:
- clk, input, 1: single clock, rising edge.
- rst, input, 1: asynchronous, active-high reset.
- in_valid, input, 1: operand pair and sel are valid.
- in_ready, output, 1: block can accept an operation.
- A, input, WIDTH: operand A.
- B, input, WIDTH: operand B.
- sel, input, 1: 0 selects add (A+B); 1 selects subtract (A+~B+1).
- out_valid, output, 1: result and flags are valid.
- out_ready, input, 1: consumer takes the result.
- S, output, WIDTH: sum/difference, modulo 2^WIDTH.
- co, output, 1: carry out of the MSB. On subtract, co=1 means no borrow (A ≥ B unsigned).
- ov, output, 1: signed overflow, equal to carry into MSB XOR carry out of MSB.
- zero, output, 1: S == 0.

## Operation
- States:
  - IDLE: in_ready=1, out_valid=0.
  - RUN: in_ready=0, out_valid=0.
  - DONE: in_ready=0, out_valid=1.
- Accept: in_valid & in_ready at a rising edge. At that edge the block:
  - latches A into the a_sh shift register;
  - latches B XOR {WIDTH{sel}} into the b_sh shift register;
  - sets carry <= sel;
  - sets cnt <= 0;
  - enters RUN.
- Each RUN cycle:
  - adds the low DIGIT bits of a_sh and b_sh plus carry;
  - shifts the DIGIT result bits into the top of the result shift register;
  - shifts a_sh and b_sh right by DIGIT;
  - updates carry;
  - increments cnt.
- On the last RUN cycle (cnt == N−1):
  - co <= final carry out;
  - ov <= carry into MSB XOR carry out of MSB (carry into the MSB comes from the last digit slice's internal chain);
  - zero is computed from the final S;
  - the block enters DONE.
- DONE: S, co, ov and zero are held stable until out_valid & out_ready, then the block returns to IDLE.
- in_valid is ignored outside IDLE. A, B and sel changing after accept have no effect.
- Carry-in is not an external port. sel alone sets the initial carry.
- Reset, asynchronous at any time including mid-RUN:
  - state=IDLE, in_ready=1, out_valid=0;
  - S=0, co=0, ov=0, zero=0;
  - cnt=0, carry=0.
  - A partial result is discarded, with no spurious out_valid.

## Timing
- Latency: out_valid rises N cycles after the accept edge (N=4 for 8/2; N=1 for DIGIT=WIDTH).
- Throughput: one operation per N+2 cycles minimum (accept, N RUN, DONE plus handshake, IDLE). There is no back-to-back accept from DONE.
- All outputs are registered. in_ready and out_valid are decoded directly from the state register, with no combinational path from in_valid or out_ready.
- Critical path: one DIGIT-bit ripple plus carry register. It is independent of WIDTH.

## Structure
- Shared package addsub_pkg:
  - state encoding (ST_IDLE, ST_RUN, ST_DONE);
  - SEL_ADD=0 and SEL_SUB=1;
  - a clog2 helper function for the cnt width.
- One sub-module, addsub_digit: a combinational DIGIT-bit ripple adder.
  - Inputs: a, b, cin.
  - Outputs: s, cout, and c_msb (the carry into its top bit).
  - Instantiated once. The top level holds the FSM, shift registers and flags.

## Test plan
All cases use WIDTH=8, DIGIT=2 unless noted.
- Add 0x3C+0x05 -> S=0x41, co=0, ov=0, zero=0. out_valid exactly 4 cycles after accept.
- Subtract 0x05−0x05 -> S=0x00, co=1, zero=1, ov=0.
- Subtract 0x03−0x05 -> S=0xFE, co=0, ov=0.
- Overflow cases:
  - add 0x7F+0x01 -> S=0x80, ov=1, co=0;
  - add 0xFF+0x01 -> S=0x00, co=1, ov=0, zero=1;
  - subtract 0x80−0x01 -> S=0x7F, ov=1, co=1.
- Backpressure:
  - hold out_ready=0 for 3 cycles in DONE -> S and flags stable, in_ready=0;
  - in_valid pulses with new operands during RUN/DONE are ignored;
  - after out_ready the block returns to IDLE, then accepts the next operation.
- Reset and alternate configuration:
  - assert rst at the 2nd RUN cycle -> outputs 0, in_ready=1 immediately, no out_valid;
  - a following add 0x10+0x20 -> S=0x30 after 4 cycles;
  - repeat the add and subtract cases with DIGIT=8 (N=1) and DIGIT=1 (N=8) -> identical results, latency N.

Source files
------------

// File: rtl/addsub_pkg.sv
// -----------------------------------------------------------------------------
// addsub_pkg
// Shared definitions for the digit-serial adder/subtractor:
//   - state_t   : FSM state encoding (ST_IDLE, ST_RUN, ST_DONE)
//   - SEL_ADD / SEL_SUB : operation select encodings for the sel input
//   - clog2()   : ceiling log2 used to size the digit counter
// -----------------------------------------------------------------------------
package addsub_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic SEL_ADD = 1'b0;
    localparam logic SEL_SUB = 1'b1;

    // Floors at 1 so a single-digit configuration still gets a 1-bit counter
    // rather than a zero-width vector.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        if (result < 1) begin
            result = 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/addsub_digit.sv
// -----------------------------------------------------------------------------
// addsub_digit
// Combinational DIGIT-bit ripple-carry adder slice.
// Ports:
//   a, b   (in,  DIGIT) : operand digits
//   cin    (in,  1)     : carry into bit 0
//   s      (out, DIGIT) : sum digit
//   cout   (out, 1)     : carry out of the top bit
//   c_msb  (out, 1)     : carry into the top bit (for signed overflow)
// -----------------------------------------------------------------------------
module addsub_digit #(
    parameter int DIGIT = 2
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             cin,
    output logic [DIGIT-1:0] s,
    output logic             cout,
    output logic             c_msb
);

    // w_chain[i] is the carry into bit i; w_chain[DIGIT] is the carry out.
    logic [DIGIT:0] w_chain;

    always_comb begin
        w_chain    = '0;
        s          = '0;
        w_chain[0] = cin;
        for (int i = 0; i < DIGIT; i++) begin
            s[i]         = a[i] ^ b[i] ^ w_chain[i];
            w_chain[i+1] = (a[i] & b[i]) | (w_chain[i] & (a[i] ^ b[i]));
        end
    end

    assign cout  = w_chain[DIGIT];
    assign c_msb = w_chain[DIGIT-1];

endmodule

// File: rtl/addsub_serial_n.sv
// -----------------------------------------------------------------------------
// addsub_serial_n
// Digit-serial two's-complement adder/subtractor. Processes a WIDTH-bit
// operand pair DIGIT bits per clock with a registered carry, taking
// N = WIDTH/DIGIT RUN cycles per operation. Valid/ready on both sides.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid / in_ready : operand handshake (in_ready only in IDLE)
//   A, B (WIDTH), sel   : operands; sel=0 add, sel=1 subtract
//   out_valid/out_ready : result handshake (out_valid only in DONE)
//   S (WIDTH)           : sum/difference modulo 2^WIDTH
//   co, ov, zero        : carry out (1 = no borrow on subtract),
//                         signed overflow, S == 0
// -----------------------------------------------------------------------------
module addsub_serial_n
    import addsub_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             co,
    output logic             ov,
    output logic             zero
);

    localparam int N     = (DIGIT >= 1) ? (WIDTH / DIGIT) : 1;
    localparam int CNT_W = clog2(N);

    generate
        if (WIDTH < 1 || DIGIT < 1 || DIGIT > WIDTH ||
            (DIGIT >= 1 && (WIDTH % DIGIT) != 0)) begin : g_badParams
            $error("addsub_serial_n: need 1 <= DIGIT <= WIDTH and WIDTH %% DIGIT == 0");
        end
    endgenerate

    state_t             r_state;
    logic [WIDTH-1:0]   r_aSh;
    logic [WIDTH-1:0]   r_bSh;
    logic [WIDTH-1:0]   r_sSh;
    logic               r_carry;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_co;
    logic               r_ov;
    logic               r_zero;

    logic [DIGIT-1:0]   w_digitSum;
    logic               w_digitCout;
    logic               w_digitCmsb;
    logic [WIDTH-1:0]   w_sNext;

    addsub_digit #(
        .DIGIT (DIGIT)
    ) u_digit (
        .a     (r_aSh[DIGIT-1:0]),
        .b     (r_bSh[DIGIT-1:0]),
        .cin   (r_carry),
        .s     (w_digitSum),
        .cout  (w_digitCout),
        .c_msb (w_digitCmsb)
    );

    // Result digits enter at the top and walk down, so after N RUN cycles
    // the first (least significant) digit has reached bit 0.
    generate
        if (DIGIT == WIDTH) begin : g_singleDigit
            assign w_sNext = w_digitSum;
        end else begin : g_multiDigit
            assign w_sNext = {w_digitSum, r_sSh[WIDTH-1:DIGIT]};
        end
    endgenerate

    // Single FSM: accept latches operands (B pre-inverted on subtract, with
    // the +1 supplied as the initial carry), RUN consumes one digit per
    // cycle, and the flags are captured from the last digit's carries.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_aSh   <= '0;
            r_bSh   <= '0;
            r_sSh   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_co    <= 1'b0;
            r_ov    <= 1'b0;
            r_zero  <= 1'b0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_aSh   <= A;
                        r_bSh   <= B ^ {WIDTH{sel == SEL_SUB}};
                        r_carry <= (sel == SEL_SUB);
                        r_cnt   <= '0;
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_sSh   <= w_sNext;
                    r_aSh   <= r_aSh >> DIGIT;
                    r_bSh   <= r_bSh >> DIGIT;
                    r_carry <= w_digitCout;
                    r_cnt   <= r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_W'(N - 1)) begin
                        r_co    <= w_digitCout;
                        r_ov    <= w_digitCmsb ^ w_digitCout;
                        r_zero  <= (w_sNext == '0);
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign S         = r_sSh;
    assign co        = r_co;
    assign ov        = r_ov;
    assign zero      = r_zero;

endmodule

// File: tb/tb_addsub_serial_n.sv
// -----------------------------------------------------------------------------
// tb_addsub_serial_n
// Drives three instances (DIGIT = 2, 1 and 8, WIDTH = 8) with shared inputs
// and checks each against hand-computed results, latencies and handshakes.
// -----------------------------------------------------------------------------
module tb_addsub_serial_n;

    localparam logic SEL_ADD = 1'b0;
    localparam logic SEL_SUB = 1'b1;

    logic       clk;
    logic       rst;
    logic       inValid;
    logic [7:0] opA;
    logic [7:0] opB;
    logic       opSel;
    logic       outReady;

    logic       inReady  [3];
    logic       outValid [3];
    logic [7:0] sOut     [3];
    logic       coOut    [3];
    logic       ovOut    [3];
    logic       zeroOut  [3];

    int assertCount;
    int failCount;

    // Expected RUN-cycle latency per instance: DIGIT=2 -> 4, DIGIT=8 -> 1, DIGIT=1 -> 8
    int latExp [3];

    addsub_serial_n #(.WIDTH(8), .DIGIT(2)) dutD2 (
        .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(inReady[0]),
        .A(opA), .B(opB), .sel(opSel), .out_valid(outValid[0]), .out_ready(outReady),
        .S(sOut[0]), .co(coOut[0]), .ov(ovOut[0]), .zero(zeroOut[0])
    );

    addsub_serial_n #(.WIDTH(8), .DIGIT(8)) dutD8 (
        .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(inReady[1]),
        .A(opA), .B(opB), .sel(opSel), .out_valid(outValid[1]), .out_ready(outReady),
        .S(sOut[1]), .co(coOut[1]), .ov(ovOut[1]), .zero(zeroOut[1])
    );

    addsub_serial_n #(.WIDTH(8), .DIGIT(1)) dutD1 (
        .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(inReady[2]),
        .A(opA), .B(opB), .sel(opSel), .out_valid(outValid[2]), .out_ready(outReady),
        .S(sOut[2]), .co(coOut[2]), .ov(ovOut[2]), .zero(zeroOut[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case a wait ever misbehaves.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Issue one operation to all instances, watch out_valid latency for each,
    // check results while held in DONE, then release with out_ready.
    task automatic applyStimulus(input string name, input logic [7:0] a, input logic [7:0] b,
                                 input logic s, input logic [7:0] expS, input logic expCo,
                                 input logic expOv, input logic expZero);
        int lat [3];
        for (int i = 0; i < 3; i++) lat[i] = -1;
        @(negedge clk);
        checkOutput($sformatf("%s_inReadyBefore", name), inReady[0], 1);
        opA = a; opB = b; opSel = s; inValid = 1'b1;
        @(posedge clk);
        #1;
        // Changing operands after accept must not disturb the running op.
        inValid = 1'b0; opA = ~a; opB = 8'h5A; opSel = ~s;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (k == 0) checkOutput($sformatf("%s_inReadyRun", name), inReady[0], 0);
            for (int i = 0; i < 3; i++) begin
                if (outValid[i] && lat[i] < 0) lat[i] = k;
            end
        end
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("%s_lat%0d", name, i), lat[i], latExp[i]);
            checkOutput($sformatf("%s_S%0d", name, i), sOut[i], expS);
            checkOutput($sformatf("%s_co%0d", name, i), coOut[i], expCo);
            checkOutput($sformatf("%s_ov%0d", name, i), ovOut[i], expOv);
            checkOutput($sformatf("%s_zero%0d", name, i), zeroOut[i], expZero);
            checkOutput($sformatf("%s_inReadyDone%0d", name, i), inReady[i], 0);
        end
        outReady = 1'b1;
        @(posedge clk);
        #1;
        outReady = 1'b0;
        @(negedge clk);
        checkOutput($sformatf("%s_idleReady", name), inReady[0], 1);
        checkOutput($sformatf("%s_idleValid", name), outValid[0], 0);
    endtask

    initial begin
        bit sawValid;
        assertCount = 0;
        failCount   = 0;
        latExp[0] = 4; latExp[1] = 1; latExp[2] = 8;
        rst = 1'b1; inValid = 1'b0; opA = '0; opB = '0; opSel = 1'b0; outReady = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("rst_inReady%0d", i), inReady[i], 1);
            checkOutput($sformatf("rst_outValid%0d", i), outValid[i], 0);
            checkOutput($sformatf("rst_S%0d", i), sOut[i], 8'h00);
            checkOutput($sformatf("rst_flags%0d", i), {coOut[i], ovOut[i], zeroOut[i]}, 3'b000);
        end
        rst = 1'b0;

        // Directed arithmetic vectors
        applyStimulus("add3C05", 8'h3C, 8'h05, SEL_ADD, 8'h41, 1'b0, 1'b0, 1'b0);
        applyStimulus("sub0505", 8'h05, 8'h05, SEL_SUB, 8'h00, 1'b1, 1'b0, 1'b1);
        applyStimulus("sub0305", 8'h03, 8'h05, SEL_SUB, 8'hFE, 1'b0, 1'b0, 1'b0);
        applyStimulus("add7F01", 8'h7F, 8'h01, SEL_ADD, 8'h80, 1'b0, 1'b1, 1'b0);
        applyStimulus("addFF01", 8'hFF, 8'h01, SEL_ADD, 8'h00, 1'b1, 1'b0, 1'b1);
        applyStimulus("sub8001", 8'h80, 8'h01, SEL_SUB, 8'h7F, 1'b1, 1'b1, 1'b0);

        // Backpressure: 0x12+0x34 while in_valid is pulsed with junk operands
        @(negedge clk);
        opA = 8'h12; opB = 8'h34; opSel = SEL_ADD; inValid = 1'b1;
        @(posedge clk);
        #1;
        inValid = 1'b0;
        for (int k = 0; k < 11; k++) begin
            @(negedge clk);
            if (k == 1) begin
                opA = 8'hFF; opB = 8'hFF; opSel = SEL_SUB; inValid = 1'b1;
            end
            if (k >= 5 && k <= 7) begin
                checkOutput($sformatf("bp_S_k%0d", k), sOut[0], 8'h46);
                checkOutput($sformatf("bp_flags_k%0d", k), {coOut[0], ovOut[0], zeroOut[0]}, 3'b000);
                checkOutput($sformatf("bp_valid_k%0d", k), outValid[0], 1);
                checkOutput($sformatf("bp_inReady_k%0d", k), inReady[0], 0);
            end
        end
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("bp_finalValid%0d", i), outValid[i], 1);
            checkOutput($sformatf("bp_finalS%0d", i), sOut[i], 8'h46);
        end
        // Release with in_valid still high: DONE must go to IDLE, not accept.
        outReady = 1'b1;
        @(posedge clk);
        #1;
        outReady = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("bp_release_inReady%0d", i), inReady[i], 1);
            checkOutput($sformatf("bp_release_outValid%0d", i), outValid[i], 0);
        end
        inValid = 1'b0;
        applyStimulus("bpNext", 8'h20, 8'h05, SEL_SUB, 8'h1B, 1'b1, 1'b0, 1'b0);

        // Reset during the second RUN cycle discards the partial result
        @(negedge clk);
        opA = 8'h55; opB = 8'h11; opSel = SEL_ADD; inValid = 1'b1;
        @(posedge clk);
        #1;
        inValid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("midRst_inReady", inReady[0], 1);
        checkOutput("midRst_outValid", outValid[0], 0);
        checkOutput("midRst_S", sOut[0], 8'h00);
        checkOutput("midRst_flags", {coOut[0], ovOut[0], zeroOut[0]}, 3'b000);
        @(negedge clk);
        rst = 1'b0;
        sawValid = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (outValid[0] || outValid[1] || outValid[2]) sawValid = 1'b1;
        end
        checkOutput("midRst_noSpuriousValid", sawValid, 0);
        checkOutput("midRst_idleReady", inReady[0], 1);

        applyStimulus("add1020", 8'h10, 8'h20, SEL_ADD, 8'h30, 1'b0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
